lsu_mem_master: RTL

- CPU-side initiator for the data-memory port. It accepts byte-addressed load/store requests from the execute stage and drives the word-organised data RAM.
- The RAM applies byte and half writes only to the low lanes of the word at addr[31:2]. This block therefore performs lane extraction, sign/zero extension and read-modify-write for sub-word stores.
- It returns a single response per request, carrying data or an error flag.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_lane_align.sv | 62 ++++++
 rtl/lsu_mem_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request-legality helpers for the data-memory master.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Stores only know B/H/W; loads additionally know BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic store_ok;
    logic load_ok;
    store_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    load_ok  = store_ok || (f3 == F3_BU) || (f3 == F3_HU);
    return we ? !store_ok : !load_ok;
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic half;
    half = (f3 == F3_H) || (f3 == F3_HU);
    return (half && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half out of the RAM word.
  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign- or zero-extend the selected lane into a full load result.
  always_comb begin
    load_data_c = rdata;
    unique case (func3)
      F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_c = {24'h0, byte_sel};
      F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_c = {16'h0, half_sel};
      default: load_data_c = rdata;
    endcase
  end

  // Overlay store data onto the read word; untouched lanes keep RAM contents.
  always_comb begin
    merge_data_c = rdata;
    unique case (func3)
      F3_B: begin
        unique case (addr_lo)
          2'd0: merge_data_c[7:0]   = wdata[7:0];
          2'd1: merge_data_c[15:8]  = wdata[7:0];
          2'd2: merge_data_c[23:16] = wdata[7:0];
          2'd3: merge_data_c[31:24] = wdata[7:0];
          default: merge_data_c = rdata;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merge_data_c[31:16] = wdata[15:0];
        else            merge_data_c[15:0]  = wdata[15:0];
      end
      default: merge_data_c = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-organised data RAM: one response per request.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [2:0]    mem_func3,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_e    state_q, state_d;
  lsu_req_t      req_q, req_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          acc_err;
  logic [DW-1:0] load_data_c;
  logic [DW-1:0] merge_data_c;

  lsu_lane_align u_align (
    .func3        (req_q.func3),
    .addr_lo      (req_q.addr[1:0]),
    .rdata        (mem_rdata),
    .wdata        (req_q.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Legality of the request currently presented on req_*.
  always_comb begin
    acc_err = f3_illegal(req_we, req_func3)
           || misaligned(req_func3, req_addr[1:0])
           || (req_addr[DW-1:2] >= (DW-2)'(MEM_WORDS));
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d       = '{we: req_we, func3: req_func3, addr: req_addr, wdata: req_wdata};
          rsp_rdata_d = '0;
          rsp_err_d   = acc_err;
          if (acc_err)                state_d = RESP;
          else if (!req_we)           state_d = LOAD;
          else if (req_func3 == F3_W) state_d = WRITE;
          else                        state_d = RMW_RD;
          if (!acc_err && req_we && (req_func3 == F3_W)) mem_wdata_d = req_wdata;
        end
      end
      LOAD: begin
        // Stores never pass through LOAD; the guard keeps store results at zero.
        rsp_rdata_d = req_q.we ? '0 : load_data_c;
        state_d     = RESP;
      end
      RMW_RD: begin
        mem_wdata_d = merge_data_c;
        state_d     = WRITE;
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory cycles always address the latched word; errors never drive a new address.
    if ((state_d == LOAD) || (state_d == RMW_RD) || (state_d == WRITE)) begin
      mem_addr_d = {req_d.addr[DW-1:2], 2'b00};
    end

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_we_d    = (state_d == WRITE);
  end

  // State and output registers; reset aborts any transfer and drops mem_we at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_func3 = F3_W;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
